stream_arb2: RTL and testbench

STREAM_ARB2 -- requirements
Module: stream_arb2

---
 rtl/stream_arb2.sv | 186 ++++++++++++++++++
 tb/tb_stream_arb2.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stream_arb2.sv
// Two-source AXI-Stream packet arbiter with a zero-latency datapath and round-robin tie break.
// Optional stall watchdog enabled by defining STALL_WATCHDOG_EN.
module stream_arb2 #(
  parameter int DW      = 512,
  parameter int FREQ_HZ = 332265625
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s0_tdata,
  input  logic          s0_tlast,
  input  logic          s0_tvalid,
  output logic          s0_tready,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tlast,
  input  logic          s1_tvalid,
  output logic          s1_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [1:0]    grant,
  output logic [15:0]   abort_count
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_state_d;
  logic   r_last_grant;
  logic   w_own_valid;
  logic   w_own_last;
  logic   w_hs;
  logic   w_abort;

  assign grant = r_state;
  assign w_hs  = w_own_valid & m_tready;

  // Steer the granted source onto the merged stream; nothing passes while idle.
  always_comb begin
    m_tdata     = '0;
    m_tlast     = 1'b0;
    m_tvalid    = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    case (r_state)
      GRANT0: begin
        m_tdata     = s0_tdata;
        m_tlast     = s0_tlast;
        m_tvalid    = s0_tvalid;
        s0_tready   = m_tready;
        w_own_valid = s0_tvalid;
        w_own_last  = s0_tlast;
      end
      GRANT1: begin
        m_tdata     = s1_tdata;
        m_tlast     = s1_tlast;
        m_tvalid    = s1_tvalid;
        s1_tready   = m_tready;
        w_own_valid = s1_tvalid;
        w_own_last  = s1_tlast;
      end
      default: begin
        m_tdata = '0;
      end
    endcase
  end

  // Arbitration: grant is only released or handed over on a tlast handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          w_next = r_last_grant ? GRANT0 : GRANT1;
        end else if (s0_tvalid) begin
          w_next = GRANT0;
        end else if (s1_tvalid) begin
          w_next = GRANT1;
        end else begin
          w_next = IDLE;
        end
      end
      GRANT0: begin
        if (w_hs && w_own_last) begin
          if (s1_tvalid) begin
            w_next = GRANT1;
          end else if (s0_tvalid) begin
            w_next = GRANT0;
          end else begin
            w_next = IDLE;
          end
        end else begin
          w_next = GRANT0;
        end
      end
      GRANT1: begin
        if (w_hs && w_own_last) begin
          if (s0_tvalid) begin
            w_next = GRANT0;
          end else if (s1_tvalid) begin
            w_next = GRANT1;
          end else begin
            w_next = IDLE;
          end
        end else begin
          w_next = GRANT1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A watchdog abort overrides the arbitration decision.
  always_comb begin
    if (w_abort) begin
      w_state_d = IDLE;
    end else begin
      w_state_d = w_next;
    end
  end

  // Arbiter state and round-robin memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_d;
      if (w_state_d == GRANT0) begin
        r_last_grant <= 1'b0;
      end else if (w_state_d == GRANT1) begin
        r_last_grant <= 1'b1;
      end else begin
        r_last_grant <= r_last_grant;
      end
    end
  end

`ifdef STALL_WATCHDOG_EN
  localparam logic [31:0] TIMEOUT = 32'(FREQ_HZ);

  logic [31:0] r_timer;
  logic [15:0] r_abort_count;

  assign w_abort     = (r_state != IDLE) && (r_timer == 32'd0);
  assign abort_count = r_abort_count;

  // Stall timer: only an absent tvalid counts, backpressure never does.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= TIMEOUT;
    end else if ((w_state_d != IDLE) && ((w_state_d != r_state) || w_hs)) begin
      r_timer <= TIMEOUT;
    end else if ((r_state != IDLE) && !w_own_valid && (r_timer != 32'd0)) begin
      r_timer <= r_timer - 32'd1;
    end else begin
      r_timer <= r_timer;
    end
  end

  // Saturating abort counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abort_count <= 16'd0;
    end else if (w_abort && (r_abort_count != 16'hFFFF)) begin
      r_abort_count <= r_abort_count + 16'd1;
    end else begin
      r_abort_count <= r_abort_count;
    end
  end
`else
  assign w_abort     = 1'b0;
  assign abort_count = 16'd0;
`endif

endmodule

// File: tb/tb_stream_arb2.sv
// Self-checking bench for stream_arb2: vector table, directed corner sequences and
// randomized cycles compared against an owner-tracking reference model.
module tb_stream_arb2;
  localparam int DW = 32;
  localparam int F  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tlast, s0_tvalid, s0_tready;
  logic          s1_tlast, s1_tvalid, s1_tready;
  logic          m_tlast, m_tvalid, m_tready;
  logic [1:0]    grant;
  logic [15:0]   abort_count;

  always #5 clk = ~clk;

  stream_arb2 #(.DW(DW), .FREQ_HZ(F)) dut (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .grant(grant), .abort_count(abort_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the output (0 none, 1 s0, 2 s1), who won last, aborts, stall budget.
  int own, last_src, aborts, budget;

  logic [1:0] g_seen;
  logic       mv_seen, r0_seen;

  typedef struct packed {
    bit       v0, l0, v1, l1;
    bit [1:0] eg;
    bit       emv;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = 0; last_src = 2; aborts = 0; budget = F;
  endtask

  task automatic model_update(input bit v0, l0, v1, l1, rdy, rst);
    int nxt;
    bit vn, ln, vo, hs;
    if (rst) begin
      model_reset();
    end else begin
      nxt = own;
      vn  = (own == 1) ? v0 : (own == 2) ? v1 : 1'b0;
      ln  = (own == 1) ? l0 : l1;
      vo  = (own == 1) ? v1 : v0;
      hs  = vn && rdy;
`ifdef STALL_WATCHDOG_EN
      if (own != 0 && budget == 0) begin
        nxt = 0;
        if (aborts < 65535) aborts = aborts + 1;
      end else
`endif
      if (own == 0) begin
        if (v0 && v1) nxt = (last_src == 2) ? 1 : 2;
        else if (v0) nxt = 1;
        else if (v1) nxt = 2;
      end else if (hs && ln) begin
        nxt = vo ? (3 - own) : (vn ? own : 0);
      end
`ifdef STALL_WATCHDOG_EN
      if (nxt != 0 && (nxt != own || hs)) budget = F;
      else if (own != 0 && !vn && budget > 0) budget = budget - 1;
`endif
      if (nxt != 0) last_src = nxt;
      own = nxt;
    end
  endtask

  // One clock cycle: drive at posedge+1, check at the falling edge, advance the model at posedge.
  task automatic step(input bit v0, l0, v1, l1, rdy, rst);
    logic [1:0]    eg;
    logic          ev, el, er0, er1;
    logic [DW-1:0] ed;
    s0_tvalid = v0; s0_tlast = l0; s1_tvalid = v1; s1_tlast = l1;
    m_tready = rdy; reset = rst;
    s0_tdata = $urandom; s1_tdata = $urandom;
    #4;
    eg  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
    ev  = (own == 1) ? v0 : (own == 2) ? v1 : 1'b0;
    el  = (own == 1) ? l0 : l1;
    ed  = (own == 1) ? s0_tdata : s1_tdata;
    er0 = (own == 1) && rdy;
    er1 = (own == 2) && rdy;
    check("cycle", {grant, m_tvalid, s0_tready, s1_tready, abort_count},
          {eg, ev, er0, er1, 16'(aborts)});
    if (ev) check("data", {m_tlast, m_tdata}, {el, ed});
    g_seen = grant; mv_seen = m_tvalid; r0_seen = s0_tready;
    @(posedge clk);
    model_update(v0, l0, v1, l1, rdy, rst);
    #1;
  endtask

  initial begin
    int n;
    int wrong;
    reset = 1'b1;
    s0_tvalid = 1'b0; s0_tlast = 1'b0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
    m_tready = 1'b0; s0_tdata = '0; s1_tdata = '0;
    @(posedge clk); #1;
    model_reset();

    // Tie after reset: s0 packet then s1 packet, six beats without a gap.
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
    check("rst_grant", {grant, abort_count}, 18'd0);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v0, tbl[i].l0, tbl[i].v1, tbl[i].l1, 1'b1, 1'b0);
      check("tbl_grant", g_seen, tbl[i].eg);
      check("tbl_mvalid", mv_seen, tbl[i].emv);
    end

    // s0 alone, back-to-back 2-beat packets: grant never drops.
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1, 0);
      check("b2b_grant", {g_seen, mv_seen}, 3'b011);
      step(1, 1, 0, 0, 1, 0);
      check("b2b_grant", {g_seen, mv_seen}, 3'b011);
    end

    // Long backpressure mid-packet is not a stall.
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 40; k++) step(1, 0, 0, 0, 0, 0);
    check("bp_grant", g_seen, 2'b01);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 0);
    check("bp_abort", abort_count, 16'd0);

    // s1 stalls after one beat while s0 waits.
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
`ifdef STALL_WATCHDOG_EN
    for (n = 0; n < 40; n++) begin
      step(1, 0, 0, 0, 1, 0);
      if (g_seen == 2'b00) break;
    end
    check("wd_delay", n, 17);
    check("wd_abort", abort_count, 16'd1);
    step(1, 0, 0, 0, 1, 0);
    check("wd_regrant", g_seen, 2'b01);
`else
    wrong = 0;
    for (n = 0; n < 1000; n++) begin
      step(1, 0, 0, 0, 1, 0);
      if (g_seen != 2'b10) wrong++;
    end
    check("hold_grant", wrong, 0);
    check("hold_abort", abort_count, 16'd0);
`endif

    // Reset during beat 2 of a 4-beat s0 packet.
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1, 0);
    check("rst_mid", {g_seen, mv_seen, r0_seen}, 4'b0000);
    step(1, 0, 1, 0, 1, 0);
    check("rst_tie", g_seen, 2'b01);

    // Randomized traffic, occasional resets.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
